// File: rtl/stack_queue_buffer.sv
// Run-time selectable LIFO/FIFO buffer with occupancy count, almost-full flag
// and sticky, clearable overflow/underflow flags.
module stack_queue_buffer #(
    parameter int N  = 4,
    parameter int WL = 3,
    parameter int AF = N - 1,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic          pop,
    input  logic [WL-1:0] di,
    input  logic          mode_sel,
    input  logic          err_clr,
    output logic [WL-1:0] data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          mode,
    output logic          ovf,
    output logic          unf,
    output logic          error
);

    localparam int PW = $clog2(N);

    logic [WL-1:0] mem [N];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW-1:0] top_addr, nxt_addr, rd_addr, wr_addr;
    logic          eff_mode, do_push, do_pop, ovf_set, unf_set;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full        = (count == CW'(N));
        empty       = (count == '0);
        almost_full = (count >= CW'(AF));
        error       = ovf | unf;

        // An edge seen while empty already operates in the newly selected mode.
        eff_mode = empty ? mode_sel : mode;
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        ovf_set  = push & ~do_push;
        unf_set  = pop & empty;

        top_addr = PW'(count - CW'(1));
        nxt_addr = PW'(count);
        rd_addr  = eff_mode ? rd_ptr : top_addr;
        // Simultaneous LIFO push/pop replaces the top slot in place.
        wr_addr  = eff_mode ? wr_ptr : (do_pop ? top_addr : nxt_addr);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            data   <= '0;
            count  <= '0;
            mode   <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (empty)
                mode <= mode_sel;
            if (do_pop)
                data <= mem[rd_addr];
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
            if (eff_mode && do_push)
                wr_ptr <= wrap_inc(wr_ptr);
            if (eff_mode && do_pop)
                rd_ptr <= wrap_inc(rd_ptr);
            // A fresh error at the clearing edge takes priority over the clear.
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && do_push)
            mem[wr_addr] <= di;
    end

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Scoreboard bench for stack_queue_buffer: directed steps queue hand-computed
// status and popped-data expectations; a monitor checks them as outputs appear.
module tb_stack_queue_buffer;

    localparam int N  = 4;
    localparam int WL = 3;
    localparam int AF = 3;
    localparam int CW = 3;
    localparam int VW = CW + 7 + WL;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [WL-1:0] di = '0;
    logic          mode_sel = 1'b0;
    logic          err_clr = 1'b0;
    logic [WL-1:0] data;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, mode, ovf, unf, error;

    stack_queue_buffer #(.N(N), .WL(WL), .AF(AF)) dut (
        .CLK(CLK), .RESET(RESET), .push(push), .pop(pop), .di(di),
        .mode_sel(mode_sel), .err_clr(err_clr), .data(data), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .mode(mode),
        .ovf(ovf), .unf(unf), .error(error)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0;
    logic pop_acc = 1'b0;
    always @(posedge CLK) cyc <= cyc + 1;
    // Accepted-pop strobe: data is presented right after this edge.
    always @(posedge CLK) pop_acc <= RESET & pop & ~empty;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [WL-1:0] dq[$];
    string         sn[$];
    int            st[$];
    logic [VW-1:0] sv[$];

    logic [WL-1:0] exp_d;
    logic [VW-1:0] exp_v, act_v;
    string         nm_c;

    initial begin
        forever begin
            @(negedge CLK);
            if (pop_acc) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_bad++;
                    $display("FAIL pop_data: unexpected accepted pop, data=%0d required no pop", data);
                end else begin
                    exp_d = dq.pop_front();
                    if (data !== exp_d) begin
                        n_bad++;
                        $display("FAIL pop_data: data=%0d required %0d", data, exp_d);
                    end
                end
            end
            while (st.size() > 0 && st[0] <= cyc) begin
                void'(st.pop_front());
                nm_c  = sn.pop_front();
                exp_v = sv.pop_front();
                act_v = {count, full, empty, almost_full, mode, ovf, unf, error, data};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s: got %b required %b (count|full|empty|afull|mode|ovf|unf|error|data)",
                             nm_c, act_v, exp_v);
                end
            end
        end
    end

    task automatic t(input string nm, input logic rn, input logic pu, input logic po,
                     input logic [WL-1:0] d, input logic ec, input logic ms,
                     input int c, input logic md, input logic ov, input logic un,
                     input logic [WL-1:0] dat, input logic pa);
        logic [CW-1:0] cc;
        @(negedge CLK);
        RESET = rn; push = pu; pop = po; di = d; err_clr = ec; mode_sel = ms;
        cc = CW'(c);
        if (pa) dq.push_back(dat);
        sn.push_back(nm);
        st.push_back(cyc + 1);
        sv.push_back({cc, (c == N), (c == 0), (c >= AF), md, ov, un, (ov | un), dat});
    endtask

    initial begin
        //  name          rn pu po di ec ms   cnt md ov un dat pa
        t("rst_a",        0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        t("rst_b",        0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        t("l_push1",      1, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        t("l_push2",      1, 1, 0, 2, 0, 0,   2, 0, 0, 0, 0, 0);
        t("l_push4",      1, 1, 0, 4, 0, 0,   3, 0, 0, 0, 0, 0);
        t("l_push5",      1, 1, 0, 5, 0, 0,   4, 0, 0, 0, 0, 0);
        t("l_ovf",        1, 1, 0, 7, 0, 0,   4, 0, 1, 0, 0, 0);
        t("l_pop5",       1, 0, 1, 0, 0, 0,   3, 0, 1, 0, 5, 1);
        t("l_pop4",       1, 0, 1, 0, 0, 0,   2, 0, 1, 0, 4, 1);
        t("l_pop2",       1, 0, 1, 0, 0, 0,   1, 0, 1, 0, 2, 1);
        t("l_pop1",       1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 1, 1);
        t("l_unf",        1, 0, 1, 0, 0, 0,   0, 0, 1, 1, 1, 0);
        t("l_clr",        1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0);
        t("f_sel",        1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 1, 0);
        t("f_push1",      1, 1, 0, 1, 0, 1,   1, 1, 0, 0, 1, 0);
        t("f_push2",      1, 1, 0, 2, 0, 1,   2, 1, 0, 0, 1, 0);
        t("f_push4",      1, 1, 0, 4, 0, 1,   3, 1, 0, 0, 1, 0);
        t("f_pop1",       1, 0, 1, 0, 0, 1,   2, 1, 0, 0, 1, 1);
        t("f_pop2",       1, 0, 1, 0, 0, 1,   1, 1, 0, 0, 2, 1);
        t("f_pop4",       1, 0, 1, 0, 0, 1,   0, 1, 0, 0, 4, 1);
        t("s_push1",      1, 1, 0, 1, 0, 0,   1, 0, 0, 0, 4, 0);
        t("s_push2",      1, 1, 0, 2, 0, 0,   2, 0, 0, 0, 4, 0);
        t("s_pp3",        1, 1, 1, 3, 0, 0,   2, 0, 0, 0, 2, 1);
        t("s_pop3",       1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 3, 1);
        t("s_push2b",     1, 1, 0, 2, 0, 0,   2, 0, 0, 0, 3, 0);
        t("s_push4",      1, 1, 0, 4, 0, 0,   3, 0, 0, 0, 3, 0);
        t("s_push5",      1, 1, 0, 5, 0, 0,   4, 0, 0, 0, 3, 0);
        t("s_pp_full",    1, 1, 1, 6, 0, 0,   4, 0, 0, 0, 5, 1);
        t("s_pop6",       1, 0, 1, 0, 0, 0,   3, 0, 0, 0, 6, 1);
        t("s_pop4",       1, 0, 1, 0, 0, 0,   2, 0, 0, 0, 4, 1);
        t("lock_idle",    1, 0, 0, 0, 0, 1,   2, 0, 0, 0, 4, 0);
        t("lock_pop2",    1, 0, 1, 0, 0, 1,   1, 0, 0, 0, 2, 1);
        t("lock_pop1",    1, 0, 1, 0, 0, 1,   0, 0, 0, 0, 1, 1);
        t("w_sel",        1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 1, 0);
        t("w_push1",      1, 1, 0, 1, 0, 1,   1, 1, 0, 0, 1, 0);
        t("w_push2",      1, 1, 0, 2, 0, 1,   2, 1, 0, 0, 1, 0);
        t("w_push3",      1, 1, 0, 3, 0, 1,   3, 1, 0, 0, 1, 0);
        t("w_push4",      1, 1, 0, 4, 0, 1,   4, 1, 0, 0, 1, 0);
        t("w_pop1",       1, 0, 1, 0, 0, 1,   3, 1, 0, 0, 1, 1);
        t("w_pop2",       1, 0, 1, 0, 0, 1,   2, 1, 0, 0, 2, 1);
        t("w_push5",      1, 1, 0, 5, 0, 1,   3, 1, 0, 0, 2, 0);
        t("w_push6",      1, 1, 0, 6, 0, 1,   4, 1, 0, 0, 2, 0);
        t("w_pop3",       1, 0, 1, 0, 0, 1,   3, 1, 0, 0, 3, 1);
        t("w_pop4",       1, 0, 1, 0, 0, 1,   2, 1, 0, 0, 4, 1);
        t("w_pop5",       1, 0, 1, 0, 0, 1,   1, 1, 0, 0, 5, 1);
        t("w_pop6",       1, 0, 1, 0, 0, 1,   0, 1, 0, 0, 6, 1);
        t("e_unf",        1, 0, 1, 0, 0, 1,   0, 1, 0, 1, 6, 0);
        t("e_clr",        1, 0, 0, 0, 1, 1,   0, 1, 0, 0, 6, 0);
        t("e_clr_unf",    1, 0, 1, 0, 1, 1,   0, 1, 0, 1, 6, 0);
        t("e_clr2",       1, 0, 0, 0, 1, 1,   0, 1, 0, 0, 6, 0);
        t("e_pp_empty",   1, 1, 1, 3, 0, 1,   1, 1, 0, 1, 6, 0);
        t("e_pop3",       1, 0, 1, 0, 0, 1,   0, 1, 0, 1, 3, 1);
        t("r_push1",      1, 1, 0, 1, 0, 0,   1, 0, 0, 1, 3, 0);
        t("r_push2",      1, 1, 0, 2, 0, 0,   2, 0, 0, 1, 3, 0);
        t("r_push4",      1, 1, 0, 4, 0, 0,   3, 0, 0, 1, 3, 0);
        t("r_push5",      1, 1, 0, 5, 0, 0,   4, 0, 0, 1, 3, 0);
        t("r_ovf",        1, 1, 0, 7, 0, 0,   4, 0, 1, 1, 3, 0);
        t("r_pop5",       1, 0, 1, 0, 0, 0,   3, 0, 1, 1, 5, 1);
        t("r_reset",      0, 1, 0, 7, 0, 1,   0, 0, 0, 0, 0, 0);
        t("r_after",      1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        @(negedge CLK);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge CLK);

        n_cmp++;
        if (dq.size() != 0) begin
            n_bad++;
            $display("FAIL pop_drain: %0d expected pops never seen, required 0", dq.size());
        end
        n_cmp++;
        if (sv.size() != 0) begin
            n_bad++;
            $display("FAIL status_drain: %0d status checks left, required 0", sv.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

endmodule
